// File: rtl/gated_event_counter.sv
// Gated event counter: counts synchronized rising edges of sig_in over a fixed
// gate window and publishes the count and window number only at window end.
module gated_event_counter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sig_in,
  output logic [3:0] Count_CT,
  output logic [3:0] Count_F,
  output logic       gate_done,
  output logic       ovf
);

  localparam int unsigned TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           acc_q, acc_d;
  logic [3:0]           count_ct_q, count_ct_d;
  logic [3:0]           count_f_q, count_f_d;
  logic                 ovf_q, ovf_d;
  logic                 gate_done_q, gate_done_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   sig_edge;
  logic [3:0]             acc_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_edge = sync_q[SYNC_STAGES-1] & ~delay_q;
  assign acc_inc  = (acc_q == 4'hF) ? acc_q : acc_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      acc_q       <= '0;
      count_ct_q  <= '0;
      count_f_q   <= '0;
      ovf_q       <= 1'b0;
      gate_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      count_ct_q  <= count_ct_d;
      count_f_q   <= count_f_d;
      ovf_q       <= ovf_d;
      gate_done_q <= gate_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    acc_d       = acc_q;
    count_ct_d  = count_ct_q;
    count_f_d   = count_f_q;
    ovf_d       = ovf_q;
    gate_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        acc_d   = '0;
        if (enable) state_d = GATE;
      end

      GATE: begin
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
          acc_d   = '0;
        end else begin
          if (sig_edge) acc_d = acc_inc;
          if (timer_q == TIMER_LAST) begin
            state_d = LATCH;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      // The edge seen while publishing seeds the next window so none is lost.
      LATCH: begin
        count_f_d   = acc_q;
        ovf_d       = (acc_q == 4'hF);
        count_ct_d  = count_ct_q + 4'd1;
        gate_done_d = 1'b1;
        acc_d       = sig_edge ? 4'd1 : 4'd0;
        timer_d     = '0;
        state_d     = enable ? GATE : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Count_CT  = count_ct_q;
  assign Count_F   = count_f_q;
  assign ovf       = ovf_q;
  assign gate_done = gate_done_q;

endmodule

// File: tb/tb_gated_event_counter.sv
// Directed bench for gated_event_counter: windows are driven from the gate_done
// boundary and each expected publication is queued, then checked on gate_done.
module tb_gated_event_counter;

  localparam int unsigned GATE_CYCLES = 40;
  localparam int unsigned SYNC_STAGES = 2;

  typedef struct packed {
    logic [3:0] ct;
    logic [3:0] f;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sig_in;
  logic [3:0] Count_CT;
  logic [3:0] Count_F;
  logic       gate_done;
  logic       ovf;

  int   assertions = 0;
  int   failures   = 0;
  exp_t expQ[$];
  logic [3:0] expCt  = 4'd0;
  logic [3:0] expF   = 4'd0;
  logic       expOvf = 1'b0;

  gated_event_counter #(
    .GATE_CYCLES(GATE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sig_in   (sig_in),
    .Count_CT (Count_CT),
    .Count_F  (Count_F),
    .gate_done(gate_done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input int observed, input int expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eCt, input logic [3:0] eF,
                             input logic eOvf, input logic eDone);
    checkValue({tag, " Count_CT"}, int'(Count_CT), int'(eCt));
    checkValue({tag, " Count_F"}, int'(Count_F), int'(eF));
    checkValue({tag, " ovf"}, int'(ovf), int'(eOvf));
    checkValue({tag, " gate_done"}, int'(gate_done), int'(eDone));
  endtask

  // Called on a negedge at a window start; returns on the negedge showing gate_done.
  task automatic applyStimulus(input int nPulses, input int startDelay, input int expEdges,
                               input int expWait);
    int   cycles;
    exp_t e;
    cycles = 0;
    expCt  = expCt + 4'd1;
    expF   = (expEdges >= 15) ? 4'd15 : 4'(expEdges);
    expOvf = (expEdges >= 15);
    e.ct   = expCt;
    e.f    = expF;
    e.ovf  = expOvf;
    expQ.push_back(e);
    repeat (startDelay) begin
      @(negedge clk);
      cycles++;
    end
    for (int i = 0; i < nPulses; i++) begin
      sig_in = 1'b1;
      @(negedge clk);
      cycles++;
      sig_in = 1'b0;
      @(negedge clk);
      cycles++;
    end
    while (!(gate_done === 1'b1 && cycles > 0) && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkValue("window period", cycles, expWait);
  endtask

  always @(negedge clk) begin
    if (gate_done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkValue("spurious gate_done", int'(gate_done), 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkValue("window Count_CT", int'(Count_CT), int'(e.ct));
        checkValue("window Count_F", int'(Count_F), int'(e.f));
        checkValue("window ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    #50;
    checkOutput("in reset", 4'd0, 4'd0, 1'b0, 1'b0);
    #150;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sig_in = ~sig_in;
      @(negedge clk);
    end
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idle after reset", 4'd0, 4'd0, 1'b0, 1'b0);

    $display("[TB] back-to-back windows of 5 pulses");
    enable = 1'b1;
    applyStimulus(5, 0, 5, 42);
    applyStimulus(5, 0, 5, 41);
    applyStimulus(5, 0, 5, 41);

    $display("[TB] saturation and recovery");
    applyStimulus(19, 0, 19, 41);
    applyStimulus(2, 0, 2, 41);

    $display("[TB] Count_CT wrap over 17 windows");
    for (int i = 0; i < 17; i++) applyStimulus(i % 4, 0, i % 4, 41);

    $display("[TB] edges at the window boundary");
    applyStimulus(1, 37, 1, 41);
    applyStimulus(1, 38, 0, 41);
    applyStimulus(2, 0, 3, 41);

    $display("[TB] enable dropped mid-window");
    for (int i = 0; i < 3; i++) begin
      sig_in = 1'b1;
      @(negedge clk);
      sig_in = 1'b0;
      @(negedge clk);
    end
    enable = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("hold after disable", expCt, expF, expOvf, 1'b0);
    enable = 1'b1;
    applyStimulus(4, 0, 4, 42);

    $display("[TB] reset asserted mid-window");
    for (int i = 0; i < 2; i++) begin
      sig_in = 1'b1;
      @(negedge clk);
      sig_in = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("async reset", 4'd0, 4'd0, 1'b0, 1'b0);
    enable = 1'b0;
    expCt  = 4'd0;
    expF   = 4'd0;
    expOvf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("after reset release", 4'd0, 4'd0, 1'b0, 1'b0);
    enable = 1'b1;
    applyStimulus(2, 0, 2, 42);

    enable = 1'b0;
    repeat (5) @(negedge clk);
    checkValue("scoreboard drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
